// File: rtl/object_sprite_if.sv
// Sprite ROM port: row address out, synchronous row data back one clock later.
interface object_sprite_if #(
  parameter int ADDR_W   = 9,
  parameter int SPRITE_W = 200
) ();
  logic [ADDR_W-1:0]   rom_addr;
  logic [SPRITE_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/object_sprite.sv
// Bouncing, animated bitmap sprite with a 3-clock pixel pipeline.
// Define OBJECT_SPRITE_MIRROR_EN to flip the bitmap horizontally while moving left.
module object_sprite #(
  parameter int SPRITE_W     = 200,
  parameter int SPRITE_H     = 150,
  parameter int X_INIT       = 430,
  parameter int Y_INIT       = 325,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int STEP         = 1,
  parameter int FRAMES       = 2,
  parameter int FRAME_PERIOD = 30,
  parameter int ADDR_W       = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  input  logic             frame_tick,
  input  logic             enable,
  object_sprite_if.master  rom,
  output logic             pixel_on,
  output logic [9:0]       x_pos,
  output logic [9:0]       y_pos
);
  localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int AW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam logic [10:0] XMAX   = 11'(H_VISIBLE - SPRITE_W);
  localparam logic [10:0] YMAX   = 11'(V_VISIBLE - SPRITE_H);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [AW-1:0]     anim_q, anim_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [2:1]        hit_pipe_q;
  logic [CW-1:0]     col_d1_q, col_d2_q, col_sel;
  logic              pixel_q, pixel_d;
  logic              hit, upd;
  logic [9:0]        row, col;

  // Returns {dir, pos}: advance one step, clamping to [0, lim] and bouncing there.
  function automatic logic [10:0] axis_step(input logic [9:0] p, input logic d,
                                            input logic [10:0] lim);
    logic [10:0] p11;
    p11 = {1'b0, p};
    if (!d) begin
      if (p11 + STEP11 >= lim) axis_step = {1'b1, lim[9:0]};
      else                     axis_step = {1'b0, p + STEP11[9:0]};
    end else begin
      if (p11 <= STEP11) axis_step = {1'b0, 10'd0};
      else               axis_step = {1'b1, p - STEP11[9:0]};
    end
  endfunction

  assign upd = frame_tick & enable;
  assign hit = ({1'b0, HCount} >= {1'b0, x_q}) && ({1'b0, HCount} < {1'b0, x_q} + 11'(SPRITE_W)) &&
               ({1'b0, VCount} >= {1'b0, y_q}) && ({1'b0, VCount} < {1'b0, y_q} + 11'(SPRITE_H));
  assign row = VCount - y_q;
  assign col = HCount - x_q;

  always_comb begin
    {dx_d, x_d} = {dx_q, x_q};
    {dy_d, y_d} = {dy_q, y_q};
    tick_d      = tick_q;
    anim_d      = anim_q;
    if (upd) begin
      {dx_d, x_d} = axis_step(x_q, dx_q, XMAX);
      {dy_d, y_d} = axis_step(y_q, dy_q, YMAX);
      if (tick_q == TW'(FRAME_PERIOD - 1)) begin
        tick_d = '0;
        anim_d = (anim_q == AW'(FRAMES - 1)) ? '0 : anim_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit) rom_addr_d = ADDR_W'(32'(anim_q) * 32'(SPRITE_H) + 32'(row));
`ifdef OBJECT_SPRITE_MIRROR_EN
    col_sel = dx_q ? CW'(SPRITE_W - 1) - col_d2_q : col_d2_q;
`else
    col_sel = col_d2_q;
`endif
    pixel_d = hit_pipe_q[2] & rom.rom_data[col_sel];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= 10'(X_INIT);
      y_q        <= 10'(Y_INIT);
      dx_q       <= 1'b0;
      dy_q       <= 1'b0;
      tick_q     <= '0;
      anim_q     <= '0;
      rom_addr_q <= '0;
      hit_pipe_q <= '0;
      col_d1_q   <= '0;
      col_d2_q   <= '0;
      pixel_q    <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      tick_q     <= tick_d;
      anim_q     <= anim_d;
      rom_addr_q <= rom_addr_d;
      // Stage 2 lines up with rom_data, which the ROM registers from rom_addr_q.
      hit_pipe_q <= {hit_pipe_q[1], hit};
      col_d1_q   <= col[CW-1:0];
      col_d2_q   <= col_d1_q;
      pixel_q    <= pixel_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign pixel_on     = pixel_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
endmodule

// File: tb/tb_object_sprite.sv
// Directed bench: full-size sprite for pixel/animation/reset checks, small sprite for bounce checks.
module tb_object_sprite;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] hc_a = '0, vc_a = '0, hc_b = '0, vc_b = '0;
  logic       tick_a = 1'b0, en_a = 1'b0, tick_b = 1'b0, en_b = 1'b0;
  logic [9:0] xa, ya, xb, yb;
  logic       pa, pb;
  int checks = 0, failures = 0;

  object_sprite_if #(.ADDR_W(9), .SPRITE_W(200)) rom_a ();
  object_sprite_if #(.ADDR_W(4), .SPRITE_W(8))   rom_b ();

  object_sprite #(.FRAME_PERIOD(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .HCount(hc_a), .VCount(vc_a),
    .frame_tick(tick_a), .enable(en_a), .rom(rom_a),
    .pixel_on(pa), .x_pos(xa), .y_pos(ya));

  object_sprite #(.SPRITE_W(8), .SPRITE_H(4), .X_INIT(3), .Y_INIT(2), .H_VISIBLE(20),
                  .V_VISIBLE(10), .STEP(4), .FRAMES(2), .FRAME_PERIOD(2), .ADDR_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .HCount(hc_b), .VCount(vc_b),
    .frame_tick(tick_b), .enable(en_b), .rom(rom_b),
    .pixel_on(pb), .x_pos(xb), .y_pos(yb));

  // ROM row pattern: bit0 = ~addr[0], bit199 = addr[0], bits 1 and 198 always set.
  function automatic logic [199:0] word_a(input logic [8:0] a);
    logic [199:0] w;
    w      = '0;
    w[0]   = ~a[0];
    w[1]   = 1'b1;
    w[198] = 1'b1;
    w[199] = a[0];
    return w;
  endfunction

  always @(posedge clk) begin
    rom_a.rom_data <= word_a(rom_a.rom_addr);
    rom_b.rom_data <= 8'hA5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic ticks_a(input int n);
    repeat (n) begin
      @(negedge clk) tick_a = 1'b1;
      @(negedge clk) tick_a = 1'b0;
    end
  endtask

  task automatic tick_b1();
    @(negedge clk) tick_b = 1'b1;
    @(negedge clk) tick_b = 1'b0;
  endtask

  // One isolated pixel on sprite A, surrounded by off-sprite pixel (0,0).
  task automatic pix_a(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic [8:0] exp_addr, input logic exp_pix);
    @(negedge clk) begin hc_a = h; vc_a = v; end
    @(negedge clk) begin hc_a = '0; vc_a = '0; end
    chk({tag, "_addr"}, 32'(rom_a.rom_addr), 32'(exp_addr));
    @(negedge clk) chk({tag, "_pre"}, 32'(pa), 32'd0);
    @(negedge clk) chk({tag, "_pix"}, 32'(pa), 32'(exp_pix));
    @(negedge clk) chk({tag, "_post"}, 32'(pa), 32'd0);
  endtask

  typedef struct {
    logic [9:0] hc;
    logic [9:0] vc;
    logic [8:0] addr;
    logic       pix;
  } vec_t;

  vec_t vecs[10];
  logic mir;
  logic [9:0] bx[7], by[7];

  initial begin
`ifdef OBJECT_SPRITE_MIRROR_EN
    mir = 1'b1;
`else
    mir = 1'b0;
`endif
    vecs[0] = '{10'd430, 10'd325, 9'd0,   1'b1};
    vecs[1] = '{10'd429, 10'd325, 9'd0,   1'b0};
    vecs[2] = '{10'd431, 10'd326, 9'd1,   1'b1};
    vecs[3] = '{10'd629, 10'd474, 9'd149, 1'b1};
    vecs[4] = '{10'd630, 10'd474, 9'd149, 1'b0};
    vecs[5] = '{10'd629, 10'd475, 9'd149, 1'b0};
    vecs[6] = '{10'd432, 10'd327, 9'd2,   1'b0};
    vecs[7] = '{10'd430, 10'd326, 9'd1,   1'b0};
    vecs[8] = '{10'd629, 10'd325, 9'd0,   1'b0};
    vecs[9] = '{10'd430, 10'd474, 9'd149, 1'b0};
    bx = '{10'd7, 10'd11, 10'd12, 10'd8, 10'd4, 10'd0, 10'd4};
    by = '{10'd6, 10'd2,  10'd0,  10'd4, 10'd6, 10'd2, 10'd0};

    repeat (2) @(negedge clk);
    chk("rst_x", 32'(xa), 32'd430);
    chk("rst_y", 32'(ya), 32'd325);
    chk("rst_pix", 32'(pa), 32'd0);
    chk("rst_addr", 32'(rom_a.rom_addr), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    ticks_a(10);
    chk("hold_x", 32'(xa), 32'd430);
    chk("hold_y", 32'(ya), 32'd325);

    for (int i = 0; i < 10; i++) pix_a($sformatf("vec%0d", i), vecs[i].hc, vecs[i].vc,
                                       vecs[i].addr, vecs[i].pix);

    // Right edge at 440 bounces x; bottom edge at 330 bounces y after 5 ticks.
    en_a = 1'b1;
    ticks_a(10);
    chk("mv10_x", 32'(xa), 32'd440);
    chk("mv10_y", 32'(ya), 32'd325);
    ticks_a(1);
    chk("mv11_x", 32'(xa), 32'd439);
    chk("mv11_y", 32'(ya), 32'd324);
    pix_a("anim1", 10'd439, 10'd324, 9'd150, !mir);
    ticks_a(1);
    chk("mv12_x", 32'(xa), 32'd438);
    pix_a("anim0", 10'd438, 10'd323, 9'd0, !mir);

    // Reset mid-line while a lit pixel streams through.
    en_a = 1'b0;
    @(negedge clk) begin hc_a = 10'd439; vc_a = 10'd323; end
    repeat (3) @(negedge clk);
    chk("line_pix", 32'(pa), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pix", 32'(pa), 32'd0);
    chk("async_x", 32'(xa), 32'd430);
    chk("async_y", 32'(ya), 32'd325);
    chk("async_addr", 32'(rom_a.rom_addr), 32'd0);
    @(negedge clk) begin reset_n = 1'b1; hc_a = 10'd431; vc_a = 10'd325; end
    @(negedge clk) chk("refill1", 32'(pa), 32'd0);
    @(negedge clk) chk("refill2", 32'(pa), 32'd0);
    @(negedge clk) chk("refill3", 32'(pa), 32'd1);
    hc_a = '0; vc_a = '0;

    // Small sprite: limits x=12, y=6, STEP=4.
    tick_b1();
    chk("b_hold_x", 32'(xb), 32'd3);
    en_b = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick_b1();
      chk($sformatf("b_t%0d_x", k + 1), 32'(xb), 32'(bx[k]));
      chk($sformatf("b_t%0d_y", k + 1), 32'(yb), 32'(by[k]));
      if (k == 1 || k == 3) begin
        @(negedge clk) begin hc_b = xb; vc_b = yb; end
        @(negedge clk) begin hc_b = '0; vc_b = '0; end
        chk($sformatf("b_anim%0d", k + 1), 32'(rom_b.rom_addr), (k == 1) ? 32'd4 : 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
